piso_serializer: RTL and testbench

- Parametrised parallel-in/serial-out serializer. It is the successor to the fixed 4-bit load/shift PISO.
- Adds configurable width, selectable bit order, a valid/ready handshake on both the parallel and serial sides, and a word-boundary marker.
- Accepts back-to-back words with no idle bubble.
- Sits between a word-oriented producer and a bit-serial link or consumer.

---
 rtl/piso_serializer.sv | 85 ++++++++
 tb/tb_piso_serializer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready on both sides.
// Ports: clk, rst_n, pi/pi_valid/pi_ready (word in), so/so_valid/so_ready/so_last (bits out), busy.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pi,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  input  logic             so_ready,
  output logic             so_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic             w_tap;
  logic             w_xfer;
  logic             w_accept;

  assign w_tap    = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
  assign w_xfer   = so_valid & so_ready;
  assign w_accept = pi_valid & pi_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        // Last bit leaving with no new word behind it
        if (w_xfer && so_last && !w_accept) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    so_valid = (r_state == SHIFT);
    busy     = so_valid;
    so_last  = so_valid & (r_cnt == '0);
    // Stale shifted bits stay in sreg after a word; mask them in IDLE
    so       = so_valid & w_tap;
    // Reload is allowed in the same cycle the last bit is taken
    pi_ready = (r_state == IDLE) | (so_valid & so_ready & so_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_sreg <= pi;
      r_cnt  <= LAST_IDX;
    end else if (w_xfer && !so_last) begin
      if (MSB_FIRST) r_sreg <= r_sreg << 1;
      else           r_sreg <= r_sreg >> 1;
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: 8b MSB-first, 8b LSB-first, 1b.
// Driver pushes expected {bit,last} per offered word; monitor pops on transfers.
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic       so_ready;
  logic [7:0] pi_m, pi_l;
  logic [0:0] pi_1;
  logic       pv_m, pv_l, pv_1;
  logic       pr_m, pr_l, pr_1;
  logic       so_m, so_l, so_1;
  logic       sv_m, sv_l, sv_1;
  logic       sl_m, sl_l, sl_1;
  logic       bz_m, bz_l, bz_1;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst_n(rst_n), .pi(pi_m), .pi_valid(pv_m), .pi_ready(pr_m),
    .so(so_m), .so_valid(sv_m), .so_ready(so_ready), .so_last(sl_m), .busy(bz_m)
  );
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst_n(rst_n), .pi(pi_l), .pi_valid(pv_l), .pi_ready(pr_l),
    .so(so_l), .so_valid(sv_l), .so_ready(so_ready), .so_last(sl_l), .busy(bz_l)
  );
  piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_1 (
    .clk(clk), .rst_n(rst_n), .pi(pi_1), .pi_valid(pv_1), .pi_ready(pr_1),
    .so(so_1), .so_valid(sv_1), .so_ready(so_ready), .so_last(sl_1), .busy(bz_1)
  );

  int         errors;
  int         checks;
  int         cyc;
  logic       rnd_rdy;
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] q2[$];
  logic       stall_p[3];
  logic       so_p[3];
  logic       last_p[3];
  int         n0, first0, last0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_word(input int i, input logic [7:0] w);
    int wd;
    int idx;
    wd = (i == 2) ? 1 : 8;
    for (int k = 0; k < wd; k++) begin
      idx = (i == 1) ? k : wd - 1 - k;
      case (i)
        0:       q0.push_back({w[idx], k == wd - 1});
        1:       q1.push_back({w[idx], k == wd - 1});
        default: q2.push_back({w[idx], k == wd - 1});
      endcase
    end
  endtask

  function automatic logic rdy(input int i);
    case (i)
      0:       return pr_m;
      1:       return pr_l;
      default: return pr_1;
    endcase
  endfunction

  task automatic set_pv(input int i, input logic v);
    case (i)
      0:       pv_m = v;
      1:       pv_l = v;
      default: pv_1 = v;
    endcase
  endtask

  // Offer one word and hold it until accepted; returns accept cycle
  task automatic send(input int i, input logic [7:0] w, output int acc_cyc);
    logic acc;
    int   t;
    push_word(i, w);
    case (i)
      0:       pi_m = w;
      1:       pi_l = w;
      default: pi_1 = w[0];
    endcase
    set_pv(i, 1'b1);
    acc = 1'b0;
    t = 0;
    acc_cyc = -1;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = rdy(i);
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      t++;
    end
    set_pv(i, 1'b0);
    if (!acc) chk($sformatf("accept_timeout%0d", i), 0, 1);
  endtask

  task automatic mon_one(input int i, input logic v, input logic s,
                         input logic l, input logic b, input logic pr);
    logic [1:0] e;
    int         qs;
    chk($sformatf("busy_eq_valid%0d", i), b, v);
    if (!v) chk($sformatf("idle_so%0d", i), {s, l}, 2'b00);
    if (stall_p[i]) chk($sformatf("stall_hold%0d", i), {v, s, l}, {1'b1, so_p[i], last_p[i]});
    if (v && so_ready) begin
      case (i)
        0:       qs = q0.size();
        1:       qs = q1.size();
        default: qs = q2.size();
      endcase
      if (qs == 0) begin
        chk($sformatf("unexpected_bit%0d", i), 1, 0);
      end else begin
        case (i)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("sb_bit%0d", i), s, e[1]);
        chk($sformatf("sb_last%0d", i), l, e[0]);
      end
      if (i == 2) chk("w1_ready_on_xfer", pr, 1);
      if (i == 0) begin
        if (n0 == 0) first0 = cyc;
        last0 = cyc;
        n0++;
      end
    end
    stall_p[i] = v && !so_ready;
    so_p[i]    = s;
    last_p[i]  = l;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        stall_p = '{default: 1'b0};
      end else begin
        mon_one(0, sv_m, so_m, sl_m, bz_m, pr_m);
        mon_one(1, sv_l, so_l, sl_l, bz_l, pr_l);
        mon_one(2, sv_1, so_1, sl_1, bz_1, pr_1);
      end
    end
  endtask

  task automatic rdy_driver();
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) so_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", q0.size() + q1.size() + q2.size(), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [4:0] outs(input int i);
    case (i)
      0:       return {so_m, sv_m, sl_m, bz_m, pr_m};
      1:       return {so_l, sv_l, sl_l, bz_l, pr_l};
      default: return {so_1, sv_1, sl_1, bz_1, pr_1};
    endcase
  endfunction

  int      a0, a1;
  logic    sched[13];
  int      gap;

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    n0       = 0;
    first0   = 0;
    last0    = 0;
    rnd_rdy  = 1'b0;
    so_ready = 1'b1;
    rst_n    = 1'b0;
    pi_m = '0; pi_l = '0; pi_1 = '0;
    pv_m = 1'b0; pv_l = 1'b0; pv_1 = 1'b0;
    stall_p = '{default: 1'b0};
    so_p    = '{default: 1'b0};
    last_p  = '{default: 1'b0};
    fork
      monitor();
      rdy_driver();
    join_none

    // Reset held 3 cycles
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_outs%0d", i), outs(i), 5'b00001);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Asynchronous reset pulse mid-word
    so_ready = 1'b0;
    send(0, 8'h5A, a0);
    @(negedge clk);
    chk("shift_before_rst", sv_m, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", outs(0), 5'b00001);
    q0.delete();
    stall_p = '{default: 1'b0};
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    so_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_bits_after_rst", sv_m, 0);
    end
    @(posedge clk);
    #1;

    // Single word MSB first
    send(0, 8'hA5, a0);
    repeat (9) @(negedge clk);
    chk("a5_end_idle", {sv_m, pr_m, so_m}, 3'b010);
    @(posedge clk);
    #1;

    // Single word LSB first
    send(1, 8'hA5, a0);
    drain();

    // Back-to-back F0 then 0F
    n0 = 0;
    send(0, 8'hF0, a0);
    send(0, 8'h0F, a1);
    chk("b2b_accept_gap", a1 - a0, 8);
    drain();
    chk("b2b_bits", n0, 16);
    chk("b2b_no_gap", last0 - first0, 15);

    // Backpressure with C3
    sched = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1};
    send(0, 8'hC3, a0);
    for (int k = 0; k < 13; k++) begin
      so_ready = sched[k];
      @(negedge clk);
      if (k == 10 || k == 11) chk("last_stall_ready_low", {pr_m, sl_m, sv_m}, 3'b011);
      @(posedge clk);
      #1;
    end
    so_ready = 1'b1;
    drain();

    // Random streams on all three widths/orders
    rnd_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 20; w++) begin
        send(i, 8'($urandom), a0);
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      drain();
    end
    rnd_rdy  = 1'b0;
    so_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
